// File: rtl/debug_display_mux.sv
// debug_display_mux: multi-channel hex seven-segment monitor.
//   clk, reset      : system clock, asynchronous active-high reset
//   ch_data         : CH_NUM packed DATA_W words, channel k at [k*DATA_W +: DATA_W]
//   btn_next        : debounced level, rising edge steps channel (manual mode)
//   auto_en         : 1 = rotate channel every AUTO_DIV frames
//   freeze          : 1 = hold snapshot and channel, scanning continues
//   ch_idx          : current channel
//   AN / BCD / DP   : active-low anodes, segments {g,f,e,d,c,b,a}, decimal point
module debug_display_mux #(
  parameter int unsigned CH_NUM   = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned AUTO_DIV = 200,
  localparam int unsigned SEL_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CH_NUM*DATA_W-1:0] ch_data,
  input  logic                     btn_next,
  input  logic                     auto_en,
  input  logic                     freeze,
  output logic [SEL_W-1:0]         ch_idx,
  output logic [DIGITS-1:0]        AN,
  output logic [6:0]               BCD,
  output logic                     DP
);

  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
  localparam int unsigned DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned FRM_W  = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
  localparam int unsigned SNAP_W = 4 * DIGITS;

  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [DIG_W-1:0]  digit_q, digit_d;
  logic [FRM_W-1:0]  frame_q, frame_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic [SNAP_W-1:0] snap_q, snap_d;
  logic              btn_q;
  logic              chg_q, chg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic              tick, frame_end, rise, step;
  logic [DATA_W-1:0] sel_word;
  logic [3:0]        nib;

  always_comb begin
    tick      = (scan_q == SCAN_W'(SCAN_DIV - 1));
    frame_end = tick && (digit_q == DIG_W'(DIGITS - 1));
    rise      = btn_next && !btn_q;
    step      = !freeze &&
                (auto_en ? (frame_end && (frame_q == FRM_W'(AUTO_DIV - 1))) : rise);

    scan_d = tick ? '0 : scan_q + 1'b1;

    digit_d = digit_q;
    if (tick) digit_d = (digit_q == DIG_W'(DIGITS - 1)) ? '0 : digit_q + 1'b1;

    frame_d = frame_q;
    if (!auto_en)
      frame_d = '0;
    else if (!freeze && frame_end)
      frame_d = (frame_q == FRM_W'(AUTO_DIV - 1)) ? '0 : frame_q + 1'b1;

    // with CH_NUM=1 the wrap compare is always true, so steps stay at 0
    ch_d = ch_q;
    if (step) ch_d = (ch_q == SEL_W'(CH_NUM - 1)) ? '0 : ch_q + 1'b1;

    // reload of the new channel is deferred one cycle so a coincident
    // frame_end still captures the old channel's word
    chg_d = (ch_d != ch_q);

    sel_word = '0;
    for (int unsigned k = 0; k < CH_NUM; k++)
      if (ch_q == SEL_W'(k)) sel_word = ch_data[k*DATA_W +: DATA_W];

    snap_d = snap_q;
    if (!freeze && (frame_end || chg_q)) snap_d = SNAP_W'(sel_word);

    nib  = '0;
    an_d = '1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (digit_q == DIG_W'(i)) nib = snap_q[4*i +: 4];
      an_d[i] = (digit_q != DIG_W'(i));
    end

    case (nib)
      4'h0:    seg_d = 7'b1000000;
      4'h1:    seg_d = 7'b1111001;
      4'h2:    seg_d = 7'b0100100;
      4'h3:    seg_d = 7'b0110000;
      4'h4:    seg_d = 7'b0011001;
      4'h5:    seg_d = 7'b0010010;
      4'h6:    seg_d = 7'b0000010;
      4'h7:    seg_d = 7'b1111000;
      4'h8:    seg_d = 7'b0000000;
      4'h9:    seg_d = 7'b0010000;
      4'hA:    seg_d = 7'b0001000;
      4'hB:    seg_d = 7'b0000011;
      4'hC:    seg_d = 7'b1000110;
      4'hD:    seg_d = 7'b0100001;
      4'hE:    seg_d = 7'b0000110;
      default: seg_d = 7'b0001110;
    endcase

    // digit_q < DIGITS, so a channel index >= DIGITS never matches
    dp_d = !(32'(digit_q) == 32'(ch_q));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_q  <= '0;
      digit_q <= '0;
      frame_q <= '0;
      ch_q    <= '0;
      snap_q  <= '0;
      btn_q   <= 1'b0;
      chg_q   <= 1'b0;
      an_q    <= '1;
      seg_q   <= '1;
      dp_q    <= 1'b1;
    end else begin
      scan_q  <= scan_d;
      digit_q <= digit_d;
      frame_q <= frame_d;
      ch_q    <= ch_d;
      snap_q  <= snap_d;
      btn_q   <= btn_next;
      chg_q   <= chg_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign ch_idx = ch_q;
  assign AN     = an_q;
  assign BCD    = seg_q;
  assign DP     = dp_q;

endmodule

// File: tb/tb_debug_display_mux.sv
module tb_debug_display_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic [47:0] ch_data;
  logic        btn_next;
  logic        auto_en;
  logic        freeze;
  logic [1:0]  ch_idx;
  logic [3:0]  AN;
  logic [6:0]  BCD;
  logic        DP;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  debug_display_mux #(
    .CH_NUM(3), .DATA_W(16), .DIGITS(4), .SCAN_DIV(4), .AUTO_DIV(2)
  ) dut (
    .clk(clk), .reset(reset), .ch_data(ch_data), .btn_next(btn_next),
    .auto_en(auto_en), .freeze(freeze), .ch_idx(ch_idx),
    .AN(AN), .BCD(BCD), .DP(DP)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // expected {AN,BCD,DP} for a slot showing digit d of word w with channel c
  function automatic logic [11:0] slot(input logic [15:0] w, input int d, input int c);
    logic [3:0] an;
    an = ~(4'b0001 << d);
    return {an, seg7(w[4*d +: 4]), (d == c) ? 1'b0 : 1'b1};
  endfunction

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic align();
    while (cyc % 16 != 0) tick();
  endtask

  task automatic pulse();
    btn_next = 1'b1; tick(); btn_next = 1'b0; tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_next = 1'b0; auto_en = 1'b0; freeze = 1'b0;
    ch_data = {16'hBEEF, 16'h1234, 16'h00A5};
    repeat (3) @(posedge clk);
    #1; reset = 1'b0; cyc = 0;
    repeat (6) tick();
    reset = 1'b1; #1;
    checks++;
    if ({AN, BCD, DP, ch_idx} !== {4'b1111, 7'b1111111, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL reset_async got=%b_%b_%b_%0d exp=1111_1111111_1_0", AN, BCD, DP, ch_idx);
    end
    @(posedge clk); #1;
    checks++;
    if ({AN, BCD, DP, ch_idx} !== {4'b1111, 7'b1111111, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL reset_hold got=%b_%b_%b_%0d exp=1111_1111111_1_0", AN, BCD, DP, ch_idx);
    end
    reset = 1'b0; cyc = 0;
    tick();
    checks++;
    if ({AN, BCD, DP} !== {4'b1110, 7'b1000000, 1'b0}) begin
      failures++;
      $display("FAIL reset_first got=%b_%b_%b exp=1110_1000000_0", AN, BCD, DP);
    end
    while (cyc < 17) tick();
    checks++;
    if ({AN, BCD} !== {4'b1110, 7'b0010010}) begin
      failures++;
      $display("FAIL reset_first_snap got=%b_%b exp=1110_0010010", AN, BCD);
    end
  endtask

  task automatic test_frame();
    logic [11:0] e;
    align();
    for (int j = 0; j < 16; j++) begin
      tick();
      e = slot(16'h00A5, j / 4, 0);
      checks++;
      if ({AN, BCD, DP} !== e) begin
        failures++;
        $display("FAIL frame_00A5 slot=%0d got=%b exp=%b", j, {AN, BCD, DP}, e);
      end
    end
  endtask

  task automatic test_manual();
    logic [1:0] exp_seq [3];
    logic [11:0] e;
    exp_seq = '{2'd1, 2'd2, 2'd0};
    for (int p = 0; p < 3; p++) begin
      pulse();
      checks++;
      if (ch_idx !== exp_seq[p]) begin
        failures++;
        $display("FAIL manual_step%0d got=%0d exp=%0d", p, ch_idx, exp_seq[p]);
      end
    end
    btn_next = 1'b1;
    repeat (20) tick();
    btn_next = 1'b0;
    tick();
    checks++;
    if (ch_idx !== 2'd1) begin
      failures++;
      $display("FAIL manual_held got=%0d exp=1", ch_idx);
    end
    pulse();
    align();
    for (int j = 0; j < 16; j++) begin
      tick();
      e = slot(16'hBEEF, j / 4, 2);
      checks++;
      if ({AN, BCD, DP} !== e) begin
        failures++;
        $display("FAIL frame_BEEF slot=%0d got=%b exp=%b", j, {AN, BCD, DP}, e);
      end
    end
  endtask

  task automatic test_auto();
    logic [1:0] e;
    pulse();  // 2 -> 0
    align();
    auto_en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      for (int j = 0; j < 16; j++) begin
        tick();
        if (j == 4) btn_next = 1'b1;
        if (j == 8) btn_next = 1'b0;
      end
      e = 2'((k / 2) % 3);
      checks++;
      if (ch_idx !== e) begin
        failures++;
        $display("FAIL auto_frame%0d got=%0d exp=%0d", k, ch_idx, e);
      end
    end
  endtask

  task automatic test_step_frame_end();
    logic [11:0] e;
    repeat (16) tick();
    checks++;
    if (ch_idx !== 2'd1) begin
      failures++;
      $display("FAIL coinc_pre got=%0d exp=1", ch_idx);
    end
    repeat (16) tick();
    checks++;
    if (ch_idx !== 2'd2) begin
      failures++;
      $display("FAIL coinc_step got=%0d exp=2", ch_idx);
    end
    for (int j = 0; j < 16; j++) begin
      tick();
      e = (j == 0) ? slot(16'h1234, 0, 2) : slot(16'hBEEF, j / 4, 2);
      checks++;
      if ({AN, BCD, DP} !== e) begin
        failures++;
        $display("FAIL coinc_frame slot=%0d got=%b exp=%b", j, {AN, BCD, DP}, e);
      end
    end
    auto_en = 1'b0;
    repeat (3) tick();
    checks++;
    if (ch_idx !== 2'd2) begin
      failures++;
      $display("FAIL auto_off_keep got=%0d exp=2", ch_idx);
    end
  endtask

  task automatic test_freeze();
    logic [11:0] e;
    pulse();  // 2 -> 0
    align();
    freeze = 1'b1;
    ch_data[15:0] = 16'hFFFF;
    for (int j = 0; j < 16; j++) begin
      tick();
      if (j == 3) btn_next = 1'b1;
      if (j == 5) btn_next = 1'b0;
      e = slot(16'h00A5, j / 4, 0);
      checks++;
      if ({AN, BCD, DP} !== e) begin
        failures++;
        $display("FAIL freeze_frame slot=%0d got=%b exp=%b", j, {AN, BCD, DP}, e);
      end
    end
    checks++;
    if (ch_idx !== 2'd0) begin
      failures++;
      $display("FAIL freeze_ch got=%0d exp=0", ch_idx);
    end
    freeze = 1'b0;
    for (int j = 0; j < 16; j++) begin
      tick();
      e = slot(16'h00A5, j / 4, 0);
      checks++;
      if ({AN, BCD, DP} !== e) begin
        failures++;
        $display("FAIL unfreeze_hold slot=%0d got=%b exp=%b", j, {AN, BCD, DP}, e);
      end
    end
    for (int j = 0; j < 16; j++) begin
      tick();
      e = slot(16'hFFFF, j / 4, 0);
      checks++;
      if ({AN, BCD, DP} !== e) begin
        failures++;
        $display("FAIL unfreeze_new slot=%0d got=%b exp=%b", j, {AN, BCD, DP}, e);
      end
    end
    checks++;
    if (ch_idx !== 2'd0) begin
      failures++;
      $display("FAIL freeze_no_queue got=%0d exp=0", ch_idx);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_manual();
    test_auto();
    test_step_frame_end();
    test_freeze();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debug_display_mux.md
Name: debug_display_mux

Overview:
- Parametrised multi-channel seven-segment monitor for the CPU board top level.
- Takes CH_NUM debug words (e.g. a0/v0/sp/ra/PC) and selects one, by button stepping or automatic rotation.
- Snapshots the selected word once per frame so digits never tear.
- Time-multiplexes the word in hex across DIGITS anodes; the decimal point marks the active channel number.

Parameters:
CH_NUM, 4, number of input channels (>=1).
DATA_W, 16, width of each channel word; must be <= 4*DIGITS, upper nibbles zero-extended.
DIGITS, 4, number of seven-segment digits / anodes (>=1).
SCAN_DIV, 50000, clk cycles per digit slot (>=2).
AUTO_DIV, 200, full scan frames per automatic channel step (>=1).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
ch_data  input  CH_NUM*DATA_W  packed channel words, channel k at bits [k*DATA_W +: DATA_W]
btn_next  input  1  debounced level; each rising edge steps channel in manual mode
auto_en  input  1  1 = automatic rotation, 0 = manual stepping
freeze  input  1  1 = hold current snapshot and channel
ch_idx  output  SEL_W  current channel, SEL_W = max(1, clog2(CH_NUM))
AN  output  DIGITS  anode enables, active low, one-hot-zero
BCD  output  7  segments {g,f,e,d,c,b,a}, active low
DP  output  1  decimal point, active low

Behaviour:
- Asynchronous active-high reset; takes effect immediately, including mid-frame.
- Values held during reset: scan_cnt=0, digit=0, frame_cnt=0, ch_idx=0, snapshot=0, btn_q=0, AN=all ones, BCD=7'b1111111, DP=1.
- Scan counter:
  - scan_cnt counts 0..SCAN_DIV-1. tick = (scan_cnt==SCAN_DIV-1), then wraps to 0.
  - On tick, digit advances 0..DIGITS-1 and wraps. frame_end = tick && digit==DIGITS-1.
- Outputs: registered, updated every clk after reset release. Latency is one cycle from a digit/snapshot change.
  - AN = ~(1<<digit).
  - BCD = hex pattern of snapshot nibble [4*digit +: 4].
  - DP = 0 iff digit==ch_idx; ch_idx>=DIGITS never lights DP.
- Hex patterns:
  0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Snapshot: loaded with channel ch_idx word (zero-extended) on frame_end, or one cycle after any ch_idx change. Not loaded while freeze=1.
- Button edge:
  - btn_q registers btn_next; rise = btn_next && !btn_q.
  - Manual mode (auto_en=0, freeze=0): rise increments ch_idx, wrapping CH_NUM-1 -> 0.
  - btn_next held high gives exactly one step.
- Auto mode (auto_en=1, freeze=0):
  - frame_cnt increments on frame_end. At AUTO_DIV-1 it wraps to 0 and ch_idx steps, same wrap as manual.
  - Button rises are ignored.
- Mode and freeze effects:
  - frame_cnt is held at 0 while auto_en=0.
  - Toggling auto_en does not change ch_idx.
  - freeze=1 stalls frame_cnt and ch_idx. Scanning continues so the display stays lit.
  - A rise during freeze is discarded, not queued.
- Channel step and frame_end in the same cycle: the snapshot takes the OLD channel, then reloads the new channel on the following cycle.
- CH_NUM=1: ch_idx is always 0; steps are no-ops.

Test Plan:
Common setup: CH_NUM=3, DATA_W=16, DIGITS=4, SCAN_DIV=4, AUTO_DIV=2; ch_data = {16'hBEEF, 16'h1234, 16'h00A5}.
1. Reset asserted mid-frame -> same cycle AN=4'b1111, BCD=7'b1111111, DP=1, ch_idx=0. Release -> next edge AN=4'b1110, and after first snapshot BCD=7'b0010010 ('5').
2. Manual mode, observe one full frame -> digits 0..3 show 5,A,0,0: AN 1110/1101/1011/0111, each held 4 cycles; DP=0 only on digit 0.
3. Manual mode, three btn_next pulses, plus one held high for 20 cycles -> ch_idx 1,2,0,1. Held pulse steps once. With ch_idx=2, frame shows F,E,E,b.
4. auto_en=1, run 8 frames -> ch_idx steps every 2 frame_ends: 0,1,2,0. btn_next pulses meanwhile cause no extra step.
5. freeze=1, then change ch_data channel 0 to 16'hFFFF and pulse btn_next -> display still shows 00A5, ch_idx unchanged. Release freeze -> next frame shows FFFF.
6. Auto step coincides with frame_end -> snapshot holds old channel one cycle, then new word; no digit shows a mixed word within the next frame.
